// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings and byte-merge helper for the dmem arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [3:0] BE_FULL   = 4'hF;
    localparam logic       PORT_CORE = 1'b0;
    localparam logic       PORT_DMA  = 1'b1;

    // Lane k takes the new byte where be[k] is set, otherwise keeps the old byte.
    function automatic logic [31:0] be_merge(input logic [31:0] wdata,
                                             input logic [31:0] old,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? wdata[8*k +: 8] : old[8*k +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-request round-robin grant; pointer flips away from the winner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       update,
    input  logic       update_id,
    output logic [1:0] grant
);

    logic r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (update) begin
            r_ptr <= ~update_id;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port round-robin front end to a single-port word memory with
//            read-modify-write handling of partial byte-enabled stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic                req_we0,
    input  logic                req_we1,
    input  logic [31:0]         req_addr0,
    input  logic [31:0]         req_addr1,
    input  logic [DATA_W-1:0]   req_wdata0,
    input  logic [DATA_W-1:0]   req_wdata1,
    input  logic [DATA_W/8-1:0] req_be0,
    input  logic [DATA_W/8-1:0] req_be1,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_id;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic [DATA_W-1:0]   r_merge;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_acc_id;
    logic                w_full;
    logic                w_partial;
    logic                w_unused;

    // Upper and sub-word address bits are intentionally dropped (aliasing).
    assign w_unused = ^{req_addr0[31:ADDR_W+2], req_addr0[1:0],
                        req_addr1[31:ADDR_W+2], req_addr1[1:0]};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .enable    ((r_state == ST_IDLE) && rst_n),
        .update    (w_accept),
        .update_id (w_acc_id),
        .grant     (w_grant)
    );

    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);
    assign w_acc_id  = w_grant[1];
    assign w_full    = r_we && (r_be == BE_FULL);
    assign w_partial = r_we && (r_be != BE_FULL) && (r_be != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = w_partial ? ST_WRITE : ST_RESP;
            ST_WRITE:  w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= PORT_CORE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_merge <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_accept) begin
                r_id    <= w_acc_id;
                r_we    <= (w_acc_id == PORT_DMA) ? req_we1    : req_we0;
                r_addr  <= (w_acc_id == PORT_DMA) ? req_addr1[ADDR_W+1:2]
                                                  : req_addr0[ADDR_W+1:2];
                r_wdata <= (w_acc_id == PORT_DMA) ? req_wdata1 : req_wdata0;
                r_be    <= (w_acc_id == PORT_DMA) ? req_be1    : req_be0;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= r_we ? '0 : mem_rdata;
                if (w_partial) begin
                    r_merge <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        mem_addr  = r_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        case (r_state)
            ST_ACCESS: begin
                if (w_full) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_wdata;
                end
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = be_merge(r_wdata, r_merge, r_be);
            end
            ST_RESP: begin
                rsp_valid = {r_id, ~r_id};
                rsp_rdata = r_rdata;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic        req_we0 = 1'b0, req_we1 = 1'b0;
    logic [31:0] req_addr0 = '0, req_addr1 = '0;
    logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [3:0]  req_be0 = '0, req_be1 = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr];

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we0(req_we0), .req_we1(req_we1),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_be0(req_be0), .req_be1(req_be1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (p == 0) begin
            req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = be;
        end else begin
            req_we1 = we; req_addr1 = addr; req_wdata1 = wdata; req_be1 = be;
        end
    endtask

    // Reference: memory as an array of words, stores merge bytes one lane at a time.
    function automatic logic [31:0] ref_apply(input logic we, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] be);
        int idx = int'(addr[11:2]);
        if (!we) return ref_mem[idx];
        for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
        return 32'h0;
    endfunction

    task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output int lat, output int wes);
        int guard = 0;
        @(negedge clk);
        drive(p, we, addr, wdata, be);
        req_valid = (p == 0) ? 2'b01 : 2'b10;
        #1;
        while (!req_ready[p] && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 20) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        lat = 0; wes = 0; rdata = 32'hX;
        for (int i = 1; i <= 6; i++) begin
            if (mem_we) wes++;
            if (rsp_valid != 2'b00) begin
                lat = i;
                rdata = rsp_rdata;
                check("rsp_port", {30'b0, rsp_valid}, (p == 0) ? 32'd1 : 32'd2);
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) check("rsp_timeout", 32'd1, 32'd0);
        @(negedge clk);
        check("rsp_one_cycle", {30'b0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [31:0] rd, exp_rd;
        int lat, wes, exp_lat, exp_wes;
        int grants[$];
        int pend[$];
        int ngr, nrsp, p;
        logic we;
        logic [31:0] addr, wdata;
        logic [3:0] be;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        vt[0]  = '{0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        2, 1};
        vt[1]  = '{0, 1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 2, 0};
        vt[2]  = '{0, 1'b1, 32'h010, 32'h11223344, 4'hF, 32'h0,        2, 1};
        vt[3]  = '{1, 1'b1, 32'h010, 32'hAABBCCDD, 4'h5, 32'h0,        3, 1};
        vt[4]  = '{1, 1'b0, 32'h010, 32'h0,        4'hF, 32'h11BB33DD, 2, 0};
        vt[5]  = '{0, 1'b1, 32'h020, 32'hFFFFFFFF, 4'h0, 32'h0,        2, 0};
        vt[6]  = '{0, 1'b0, 32'h020, 32'h0,        4'h0, 32'h0,        2, 0};
        vt[7]  = '{1, 1'b1, 32'h1000, 32'h5,       4'hF, 32'h0,        2, 1};
        vt[8]  = '{0, 1'b0, 32'h000, 32'h0,        4'h0, 32'h5,        2, 0};
        vt[9]  = '{1, 1'b1, 32'hFFC, 32'h12345678, 4'h8, 32'h0,        3, 1};
        vt[10] = '{1, 1'b0, 32'hFFF, 32'h0,        4'h0, 32'h12000000, 2, 0};

        // Reset state, with both ports requesting.
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h4, 32'h0, 4'h0);
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_ready", {30'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            void'(ref_apply(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be));
            do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, lat, wes);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
            check($sformatf("vec%0d_writes", i), wes, vt[i].exp_wes);
        end
        check("rmw_mem4", tb_mem[4], 32'h11BB33DD);
        check("alias_mem0", tb_mem[0], 32'h5);
        check("rmw_mem1023", tb_mem[1023], 32'h12000000);

        // Reset asserted while a partial store is in its write phase.
        @(negedge clk);
        drive(1, 1'b1, 32'h010, 32'hCAFEF00D, 4'h3);
        req_valid = 2'b10;
        #1;
        check("rmwrst_ready", {30'b0, req_ready}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        check("rmwrst_write_phase", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmwrst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rmwrst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        check("rmwrst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rmwrst_mem_wdata", mem_wdata, 32'd0);
        check("rmwrst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rmwrst_no_rsp", {30'b0, rsp_valid}, 32'd0);
        end
        check("rmwrst_mem_intact", tb_mem[4], ref_mem[4]);

        // Contention straight out of reset: grants alternate starting at port 0.
        drive(0, 1'b0, 32'h010, 32'h0, 4'h0);
        drive(1, 1'b0, 32'hFFC, 32'h0, 4'h0);
        req_valid = 2'b11;
        rst_n = 1'b1;
        ngr = 0; nrsp = 0;
        for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
            #1;
            check("cont_onehot_ready", {31'b0, req_ready == 2'b11}, 32'd0);
            if (rsp_valid != 2'b00) begin
                p = (pend.size() > 0) ? pend.pop_front() : -1;
                check("cont_rsp_port", {30'b0, rsp_valid}, (p == 1) ? 32'd2 : 32'd1);
                check("cont_rsp_rdata", rsp_rdata, (p == 1) ? ref_mem[1023] : ref_mem[4]);
                nrsp++;
            end
            if ((req_valid & req_ready) != 2'b00) begin
                grants.push_back(int'(req_ready[1]));
                pend.push_back(int'(req_ready[1]));
                ngr++;
            end
            @(negedge clk);
            if (ngr == 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        check("cont_rsp_count", nrsp, 32'd4);
        check("cont_grant_count", grants.size(), 32'd4);
        for (int k = 0; k < grants.size(); k++)
            check($sformatf("cont_grant%0d", k), grants[k], k % 2);

        // Random single-port traffic against the array model.
        for (int t = 0; t < 60; t++) begin
            p     = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom & ~32'h0000_0FFC) | (32'($urandom_range(0, 15)) << 2);
            wdata = $urandom;
            case ($urandom_range(0, 3))
                0:       be = 4'hF;
                1:       be = 4'h0;
                default: be = 4'($urandom);
            endcase
            exp_rd  = ref_apply(we, addr, wdata, be);
            exp_lat = (we && be != 4'h0 && be != 4'hF) ? 3 : 2;
            exp_wes = (we && be != 4'h0) ? 1 : 0;
            do_txn(p, we, addr, wdata, be, rd, lat, wes);
            check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            check($sformatf("rnd%0d_latency", t), lat, exp_lat);
            check($sformatf("rnd%0d_writes", t), wes, exp_wes);
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem%0d", i), tb_mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
